data_sram_responder: RTL and testbench

- Slave-side model of the data SRAM port consumed by the memory stage.
- Accepts sram-like requests (req/addr_ok) and returns responses (data_ok/rdata) after a fixed latency, in order.
- Used as the data memory in core-level simulation and as the target for memory-stage verification.
- Word-organised storage with byte-strobe writes and a bounded number of outstanding requests.

---
 rtl/data_sram_responder.sv | 135 +++++++++++++
 tb/tb_data_sram_responder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Slave-side model of the data SRAM port used by the memory stage. Requests
// are accepted with a req/addr_ok handshake. Each accepted request gets exactly
// one data_ok pulse, LATENCY cycles after it was accepted. Responses come back
// in acceptance order.
//
// Storage is 2**ADDR_WIDTH 32-bit words, held as four byte lanes so that
// byte-strobe writes map onto per-lane write enables. A lane is written, or
// its word is sampled for a read, on the edge at which the request is
// accepted.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   resetn   - synchronous active-low reset (clears the response pipe and the
//              outstanding count; the memory contents are kept)
//   req      - request valid
//   wr       - 1 = write, 0 = read
//   size     - access size; informational only
//   addr     - byte address; word index = addr[ADDR_WIDTH+1:2]
//   wstrb    - byte write enables (writes only)
//   wdata    - write data
//   addr_ok  - request accepted this cycle when req && addr_ok
//   data_ok  - one-cycle response pulse per accepted request
//   rdata    - read data while data_ok is high for a read, otherwise 0
// ---------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic [31:0]           last_data;

    // Response pipe control: one bit per stage. Bit 0 is loaded at acceptance,
    // and the top bit is the stage that is presented on data_ok.
    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    valid_d;
    logic [LATENCY-1:0]    wr_q;
    logic [LATENCY-1:0]    wr_d;
    logic [CNT_W-1:0]      outstanding_q;
    logic [CNT_W-1:0]      outstanding_d;

    // Upper address bits alias onto the array, and size has no effect.
    logic                  unused_ok;
    assign unused_ok = &{1'b0, size, addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign word_idx = addr[ADDR_WIDTH+1:2];

    // addr_ok depends only on registered state and resetn. It never depends
    // on req, so the requester sees no combinational loop.
    assign addr_ok = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) && resetn;
    assign accept  = req && addr_ok;

    assign data_ok = valid_q[LATENCY-1];

    always_comb begin
        rdata = '0;
        if (data_ok && !wr_q[LATENCY-1]) begin
            rdata = last_data;
        end
    end

    always_comb begin
        valid_d       = valid_q << 1;
        valid_d[0]    = accept;
        wr_d          = wr_q << 1;
        wr_d[0]       = accept && wr;
        outstanding_d = outstanding_q;
        // When a response retires in the same cycle as a new acceptance,
        // the two cancel and the count does not change.
        case ({accept, data_ok})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q       <= '0;
            wr_q          <= '0;
            outstanding_q <= '0;
        end else begin
            valid_q       <= valid_d;
            wr_q          <= wr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Byte lanes. Each lane holds its own storage and its own slice of the
    // response data pipe. Stage 0 is the registered read of the array. Stage
    // data is left unreset because the valid/wr bits decide whether it is
    // ever shown on rdata.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem    [DEPTH];
            logic [7:0] lane_pipe_q [LATENCY];

            always_ff @(posedge clk) begin
                if (accept && wr && wstrb[gi]) begin
                    lane_mem[word_idx] <= wdata[8*gi +: 8];
                end
                if (accept && !wr) begin
                    lane_pipe_q[0] <= lane_mem[word_idx];
                end
                for (int s = 1; s < LATENCY; s++) begin
                    lane_pipe_q[s] <= lane_pipe_q[s-1];
                end
            end

            assign last_data[8*gi +: 8] = lane_pipe_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    localparam int AW    = 10;
    localparam int L     = 2;
    localparam int MAXO  = 2;
    localparam int DEPTH = 1 << AW;
    localparam int LOGN  = 8192;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    data_sram_responder #(
        .ADDR_WIDTH      (AW),
        .LATENCY         (L),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int txn    = 0;
    bit mon_en = 0;

    // Per-cycle log of the DUT outputs, indexed by cycle number.
    logic        obs_dok   [LOGN];
    logic        obs_aok   [LOGN];
    logic [31:0] obs_rdata [LOGN];

    // Reference model: a flat word memory plus a queue of pending responses,
    // each tagged with the cycle in which its data_ok is due.
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];

    typedef struct packed {
        int          due;
        logic        wr;
        logic        known;
        logic [31:0] data;
    } rsp_t;

    rsp_t rsp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle c is the interval that follows the c-th rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard, sampled at the falling edge.
    initial begin
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        bit          known;
        rsp_t        e;
        int          idx;
        forever begin
            @(negedge clk);
            if (cyc < LOGN) begin
                obs_dok[cyc]   = data_ok;
                obs_aok[cyc]   = addr_ok;
                obs_rdata[cyc] = rdata;
            end
            if (mon_en) begin
                exp_aok = (rsp_q.size() < MAXO) && resetn;
                checks++;
                if (addr_ok !== exp_aok) begin
                    errors++;
                    $display("FAIL addr_ok cyc=%0d got=%b expected=%b", cyc, addr_ok, exp_aok);
                end
                exp_dok = 1'b0;
                exp_rd  = 32'h0;
                known   = 1'b1;
                if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                    e       = rsp_q.pop_front();
                    exp_dok = 1'b1;
                    exp_rd  = e.wr ? 32'h0 : e.data;
                    known   = e.known;
                end
                checks++;
                if (data_ok !== exp_dok) begin
                    errors++;
                    $display("FAIL data_ok cyc=%0d got=%b expected=%b", cyc, data_ok, exp_dok);
                end
                if (known) begin
                    checks++;
                    if (rdata !== exp_rd) begin
                        errors++;
                        $display("FAIL rdata cyc=%0d got=%h expected=%h", cyc, rdata, exp_rd);
                    end
                end
                if (!resetn) begin
                    rsp_q.delete();
                end else if (req && exp_aok) begin
                    idx   = int'(addr >> 2) % DEPTH;
                    e.due = cyc + L;
                    e.wr  = wr;
                    if (wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                        end
                        if (wstrb == 4'hF) mdl_known[idx] = 1'b1;
                        e.data  = 32'h0;
                        e.known = 1'b1;
                        $display("txn %0d: cyc=%0d write addr=%h wstrb=%h wdata=%h", txn, cyc + 1, addr, wstrb, wdata);
                    end else begin
                        e.data  = mdl_mem[idx];
                        e.known = mdl_known[idx];
                        $display("txn %0d: cyc=%0d read  addr=%h expect=%h", txn, cyc + 1, addr, e.data);
                    end
                    txn++;
                    rsp_q.push_back(e);
                end
            end
        end
    end

    // Present one request and keep it until it is accepted. acc returns the
    // cycle of the accepting edge, or -1 on timeout. Call this task, and
    // return from it, 1 time unit after a rising edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int acc);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = d;
        size  = 2'($urandom_range(0, 2));
        acc   = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr_ok === 1'b1) begin
                acc = cyc + 1;
                break;
            end
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got=no acceptance required=acceptance within 20 cycles", a);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (data_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_data_ok got=%b required=0", data_ok);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got=%h required=0", rdata);
        end
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_addr_ok got=%b required=1", addr_ok);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read;
        int aw;
        int ar;
        do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, aw);
        do_req(1'b0, 32'h10, 4'h0, 32'h0, ar);
        idle(L + 2);
        if (aw >= 0 && ar >= 0) begin
            checks++;
            if (ar != aw + 1) begin
                errors++;
                $display("FAIL wr_rd_accept got=%0d required=%0d", ar, aw + 1);
            end
            checks++;
            if (obs_dok[aw + L - 2] !== 1'b0) begin
                errors++;
                $display("FAIL wr_early_data_ok got=%b required=0", obs_dok[aw + L - 2]);
            end
            checks++;
            if (obs_dok[aw + L - 1] !== 1'b1 || obs_rdata[aw + L - 1] !== 32'h0) begin
                errors++;
                $display("FAIL wr_response got=%b/%h required=1/00000000", obs_dok[aw + L - 1], obs_rdata[aw + L - 1]);
            end
            checks++;
            if (obs_dok[ar + L - 1] !== 1'b1 || obs_rdata[ar + L - 1] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL rd_response got=%b/%h required=1/deadbeef", obs_dok[ar + L - 1], obs_rdata[ar + L - 1]);
            end
        end
    endtask

    task automatic test_strobe_merge;
        int a0;
        int a1;
        int ar;
        do_req(1'b1, 32'h20, 4'hF, 32'h11223344, a0);
        do_req(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, a1);
        do_req(1'b0, 32'h20, 4'h0, 32'h0, ar);
        idle(L + 2);
        if (ar >= 0) begin
            checks++;
            if (obs_dok[ar + L - 1] !== 1'b1 || obs_rdata[ar + L - 1] !== 32'h11BB33DD) begin
                errors++;
                $display("FAIL strobe_merge got=%b/%h required=1/11bb33dd", obs_dok[ar + L - 1], obs_rdata[ar + L - 1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int a;
        int a1;
        int a2;
        int a3;
        do_req(1'b1, 32'h0, 4'hF, 32'd1, a);
        do_req(1'b1, 32'h4, 4'hF, 32'd2, a);
        do_req(1'b1, 32'h8, 4'hF, 32'd3, a);
        idle(L + 2);
        do_req(1'b0, 32'h0, 4'h0, 32'h0, a1);
        do_req(1'b0, 32'h4, 4'h0, 32'h0, a2);
        do_req(1'b0, 32'h8, 4'h0, 32'h0, a3);
        idle(L + 3);
        if (a1 >= 0 && a2 >= 0 && a3 >= 0) begin
            checks++;
            if (a2 != a1 + 1) begin
                errors++;
                $display("FAIL b2b_second_accept got=%0d required=%0d", a2, a1 + 1);
            end
            checks++;
            if (a3 != a1 + L + 1) begin
                errors++;
                $display("FAIL b2b_third_accept got=%0d required=%0d", a3, a1 + L + 1);
            end
            checks++;
            if (obs_aok[a1 + L - 1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_full_addr_ok got=%b required=0", obs_aok[a1 + L - 1]);
            end
            checks++;
            if (obs_rdata[a1 + L - 1] !== 32'd1 || obs_rdata[a2 + L - 1] !== 32'd2 || obs_rdata[a3 + L - 1] !== 32'd3) begin
                errors++;
                $display("FAIL b2b_order got=%h,%h,%h required=1,2,3", obs_rdata[a1 + L - 1], obs_rdata[a2 + L - 1], obs_rdata[a3 + L - 1]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int aw;
        int ar;
        int ar2;
        int pulses;
        do_req(1'b1, 32'h40, 4'hF, 32'h5A5A1234, aw);
        idle(L + 2);
        do_req(1'b0, 32'h40, 4'h0, 32'h0, ar);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(L + 3);
        if (ar >= 0) begin
            pulses = 0;
            for (int c = ar; c <= ar + L + 2; c++) begin
                if (obs_dok[c] !== 1'b0) pulses++;
            end
            checks++;
            if (pulses != 0) begin
                errors++;
                $display("FAIL reset_mid_no_response got=%0d pulses required=0", pulses);
            end
            checks++;
            if (obs_aok[ar + 1] !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_addr_ok got=%b required=1", obs_aok[ar + 1]);
            end
        end
        do_req(1'b0, 32'h40, 4'h0, 32'h0, ar2);
        idle(L + 2);
        if (ar2 >= 0) begin
            checks++;
            if (obs_dok[ar2 + L - 1] !== 1'b1 || obs_rdata[ar2 + L - 1] !== 32'h5A5A1234) begin
                errors++;
                $display("FAIL reset_mid_retained got=%b/%h required=1/5a5a1234", obs_dok[ar2 + L - 1], obs_rdata[ar2 + L - 1]);
            end
        end
    endtask

    task automatic test_alias;
        int aw;
        int ar;
        do_req(1'b1, 32'h1000, 4'hF, 32'hC0FFEE01, aw);
        do_req(1'b0, 32'h0, 4'h0, 32'h0, ar);
        idle(L + 2);
        if (ar >= 0) begin
            checks++;
            if (obs_dok[ar + L - 1] !== 1'b1 || obs_rdata[ar + L - 1] !== 32'hC0FFEE01) begin
                errors++;
                $display("FAIL alias got=%b/%h required=1/c0ffee01", obs_dok[ar + L - 1], obs_rdata[ar + L - 1]);
            end
        end
    endtask

    task automatic test_random;
        int acc;
        int issued;
        int seen;
        int start_cyc;
        int end_cyc;
        int idx;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 32'(i * 4), 4'hF, $urandom, acc);
        end
        idle(L + 2);
        start_cyc = cyc;
        issued    = 0;
        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, 15);
            a   = ($urandom & 32'hFFFF_F003) | 32'(idx << 2);
            do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, acc);
            if (acc >= 0) issued++;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(L + 3);
        end_cyc = cyc;
        seen    = 0;
        for (int c = start_cyc; c < end_cyc && c < LOGN; c++) begin
            if (obs_dok[c] === 1'b1) seen++;
        end
        checks++;
        if (seen != issued) begin
            errors++;
            $display("FAIL random_response_count got=%0d required=%0d", seen, issued);
        end
    endtask

    initial begin
        resetn = 1'b0;
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'd0;
        addr   = 32'h0;
        wstrb  = 4'h0;
        wdata  = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]   = 32'h0;
            mdl_known[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        test_reset;
        test_write_read;
        test_strobe_merge;
        test_back_to_back;
        test_reset_mid;
        test_alias;
        test_random;

        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending responses required=0", rsp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
